// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM arbiter and cursor editor.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    WRITE
  } cur_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_CUR
  } owner_t;

endpackage

// File: rtl/ram_arbiter_btn_edge_sync.sv
// Two-flop synchronizer per raw button bit plus a one-cycle pulse on each
// synchronized 1->0 transition. Flops reset to the released (high) level.
module btn_edge_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn,
  output logic [W-1:0] fall
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;
      logic last_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
          last_reg <= 1'b1;
        end else begin
          meta_reg <= btn[gi];
          sync_reg <= meta_reg;
          last_reg <= sync_reg;
        end
      end

      assign fall[gi] = last_reg & ~sync_reg;
    end
  endgenerate

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between a pipelined display reader (fixed
// priority) and a button-driven cursor that reads and increments bytes.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        btn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] q,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam int STV_W = $clog2(STARVE_LIM + 1);

  logic [2:0]        fall;
  cur_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic [DATA_W-1:0] q_reg, q_next;
  logic              modify_reg, modify_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [STV_W-1:0]  starve_reg;
  logic [ADDR_W-1:0] ram_address_reg;
  logic [DATA_W-1:0] ram_data_reg;
  logic              ram_wren_reg;
  logic [DATA_W-1:0] rdata_reg;
  owner_t            tag_reg [RD_LAT+1];
  owner_t            tag_in;
  logic              cur_want;
  logic              cur_wins;
  logic [DATA_W-1:0] wr_data;

  btn_edge_sync #(.W(3)) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .fall (fall)
  );

  // Display holds priority unless the cursor has waited out its starvation limit.
  assign cur_want = (state_reg == FETCH) || (state_reg == WRITE);
  assign cur_wins = cur_want && (!disp_req || (starve_reg == STV_W'(STARVE_LIM)));
  assign disp_gnt = disp_req && !cur_wins;
  assign wr_data  = q_reg + DATA_W'(1);

  always_comb begin
    state_next    = state_reg;
    address_next  = address_reg;
    q_next        = q_reg;
    modify_next   = modify_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (fall[2]) begin
          modify_next = 1'b1;
          state_next  = FETCH;
        end else if (fall[0]) begin
          address_next = address_reg + ADDR_W'(1);
          state_next   = FETCH;
        end else if (fall[1]) begin
          address_next = address_reg - ADDR_W'(1);
          state_next   = FETCH;
        end
      end
      FETCH: begin
        if (cur_wins) begin
          wait_cnt_next = '0;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        // rdata_reg holds our read by the last counted cycle.
        if (wait_cnt_reg == CNT_W'(RD_LAT)) begin
          q_next     = rdata_reg;
          state_next = modify_reg ? WRITE : IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end
      WRITE: begin
        if (cur_wins) begin
          q_next      = wr_data;
          modify_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= FETCH;
      address_reg  <= '0;
      q_reg        <= '0;
      modify_reg   <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      address_reg  <= address_next;
      q_reg        <= q_next;
      modify_reg   <= modify_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_reg <= '0;
    end else if (cur_want && !cur_wins) begin
      starve_reg <= starve_reg + STV_W'(1);
    end else begin
      starve_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_address_reg <= '0;
      ram_data_reg    <= '0;
      ram_wren_reg    <= 1'b0;
    end else if (cur_wins) begin
      ram_address_reg <= address_reg;
      ram_wren_reg    <= (state_reg == WRITE);
      if (state_reg == WRITE) begin
        ram_data_reg <= wr_data;
      end
    end else if (disp_gnt) begin
      ram_address_reg <= disp_addr;
      ram_wren_reg    <= 1'b0;
    end else begin
      ram_wren_reg    <= 1'b0;
    end
  end

  always_comb begin
    tag_in = OWN_NONE;
    if (cur_wins) begin
      tag_in = (state_reg == WRITE) ? OWN_NONE : OWN_CUR;
    end else if (disp_gnt) begin
      tag_in = OWN_DISP;
    end
  end

  // Stage RD_LAT of the tag pipe lines up with the registered read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_reg[i] <= OWN_NONE;
      end
      rdata_reg <= '0;
    end else begin
      tag_reg[0] <= tag_in;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
      if (tag_reg[RD_LAT-1] != OWN_NONE) begin
        rdata_reg <= ram_q;
      end
    end
  end

  assign disp_rvalid = (tag_reg[RD_LAT] == OWN_DISP);
  assign disp_rdata  = rdata_reg;
  assign ram_address = ram_address_reg;
  assign ram_data    = ram_data_reg;
  assign ram_wren    = ram_wren_reg;
  assign address     = address_reg;
  assign q           = q_reg;
  assign busy        = (state_reg != IDLE);

endmodule
